// File: rtl/step_op_decoder_pkg.sv
// Shared types and the step-to-op decode function for the step-counter
// receiver.
package step_op_pkg;

    typedef enum logic [1:0] {
        OP_INC1 = 2'b00,
        OP_DEC1 = 2'b01,
        OP_INC2 = 2'b10,
        OP_DEC2 = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LOST  = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic legal;
        op_t  op;
    } dec_t;

    // Map a modular step (already reduced to w bits, zero-extended) to its op.
    // w must be at least 3 so that +2 and -2 are distinct, and below 32.
    function automatic dec_t delta_to_op(input logic [31:0] delta, input int unsigned w);
        logic [31:0] mask;
        dec_t        res;
        mask      = (32'd1 << w) - 32'd1;
        res.legal = 1'b1;
        res.op    = OP_INC1;
        if (delta == 32'd1) begin
            res.op = OP_INC1;
        end else if (delta == mask) begin
            res.op = OP_DEC1;
        end else if (delta == 32'd2) begin
            res.op = OP_INC2;
        end else if (delta == mask - 32'd1) begin
            res.op = OP_DEC2;
        end else begin
            res.legal = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/step_op_decoder_if.sv
// Sample stream in, decoded op / error / lock status out.
// Handshake: in_valid qualifies value for exactly one cycle; there is no
// ready, the receiver always accepts. op_valid and err are single-cycle
// pulses; op_out is meaningful only when op_valid is high and holds otherwise.
interface step_op_decoder_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] value;
    logic [1:0]   op_out;
    logic         op_valid;
    logic         err;
    logic         locked;

    modport master (
        output in_valid, value,
        input  op_out, op_valid, err, locked
    );

    modport slave (
        input  in_valid, value,
        output op_out, op_valid, err, locked
    );
endinterface

// File: rtl/step_op_decoder_sat_counter.sv
// Saturating statistics counter with synchronous clear that wins over inc.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up to all-ones and stick there; clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/step_op_decoder.sv
// Step-counter receiver: recovers the op behind each counter step, flags
// illegal steps while tracking, and keeps saturating per-op / error counts.
module step_op_decoder
    import step_op_pkg::*;
#(
    parameter int W         = 8,
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    step_op_decoder_if.slave  bus,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  cnt_inc1,
    output logic [CNT_W-1:0]  cnt_dec1,
    output logic [CNT_W-1:0]  cnt_inc2,
    output logic [CNT_W-1:0]  cnt_dec2,
    output logic [CNT_W-1:0]  err_cnt,
    output dec_state_t        state_dbg
);

    localparam int CW = $clog2(ERR_LIMIT + 1);

    dec_state_t    state;
    logic [W-1:0]  prev;
    logic [CW-1:0] consec_err;
    logic [W-1:0]  delta;
    dec_t          dec;
    logic          track_legal;
    logic          track_illegal;

    // Modular step from the previous sample and its decoded op.
    always_comb begin
        delta         = bus.value - prev;
        dec           = delta_to_op(32'(delta), W);
        track_legal   = bus.in_valid && (state == TRACK) && dec.legal;
        track_illegal = bus.in_valid && (state == TRACK) && !dec.legal;
    end

    assign state_dbg = state;

    // Lock state machine with registered op/err pulses and lock flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev         <= '0;
            consec_err   <= '0;
            bus.op_out   <= 2'b00;
            bus.op_valid <= 1'b0;
            bus.err      <= 1'b0;
            bus.locked   <= 1'b0;
        end else begin
            bus.op_valid <= 1'b0;
            bus.err      <= 1'b0;
            if (bus.in_valid) begin
                prev <= bus.value;
                case (state)
                    IDLE: begin
                        state      <= TRACK;
                        bus.locked <= 1'b1;
                    end
                    TRACK: begin
                        if (dec.legal) begin
                            bus.op_valid <= 1'b1;
                            bus.op_out   <= dec.op;
                            consec_err   <= '0;
                        end else begin
                            bus.err <= 1'b1;
                            if (consec_err == CW'(ERR_LIMIT - 1)) begin
                                state      <= LOST;
                                bus.locked <= 1'b0;
                                consec_err <= '0;
                            end else begin
                                consec_err <= consec_err + 1'b1;
                            end
                        end
                    end
                    LOST: begin
                        // Re-acquire silently on the first legal step.
                        if (dec.legal) begin
                            state      <= TRACK;
                            bus.locked <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        bus.locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_inc1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_stats),
        .inc(track_legal && (dec.op == OP_INC1)), .count(cnt_inc1)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_dec1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_stats),
        .inc(track_legal && (dec.op == OP_DEC1)), .count(cnt_dec1)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_inc2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_stats),
        .inc(track_legal && (dec.op == OP_INC2)), .count(cnt_inc2)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_dec2 (
        .clk(clk), .rst_n(rst_n), .clr(clr_stats),
        .inc(track_legal && (dec.op == OP_DEC2)), .count(cnt_dec2)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr_stats),
        .inc(track_illegal), .count(err_cnt)
    );

endmodule

// File: tb/tb_step_op_decoder.sv
// Bench for step_op_decoder: vector tables per scenario, per-cycle scoreboard
// of {op_valid, op_out, err, locked}, plus counter and reset checks.
module tb_step_op_decoder;
    import step_op_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 2;

    typedef struct {
        logic         iv;
        logic [W-1:0] val;
        logic         clr;
        logic [4:0]   exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             clr_stats;
    logic [CNT_W-1:0] cnt_inc1, cnt_dec1, cnt_inc2, cnt_dec2, err_cnt;
    dec_state_t       state_dbg;

    step_op_decoder_if #(.W(W)) bus ();

    step_op_decoder #(.W(W), .CNT_W(CNT_W), .ERR_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stats(clr_stats),
        .cnt_inc1(cnt_inc1), .cnt_dec1(cnt_dec1), .cnt_inc2(cnt_inc2),
        .cnt_dec2(cnt_dec2), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    int n_vec;
    int n_bad;
    logic [4:0] exp_q[$];
    vec_t vecs[$];

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] e(input logic ov, input logic [1:0] op,
                                     input logic er, input logic lk);
        return {ov, op, er, lk};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic add(input logic iv, input logic [W-1:0] val, input logic clr,
                       input logic [4:0] exp);
        vec_t v;
        v.iv = iv; v.val = val; v.clr = clr; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive each vector at negedge, score the registered outputs after posedge.
    task automatic run_vecs(input string tag);
        logic [4:0] act;
        logic [4:0] req;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.in_valid = vecs[i].iv;
            bus.value    = vecs[i].val;
            clr_stats    = vecs[i].clr;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            act = {bus.op_valid, bus.op_out, bus.err, bus.locked};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s[%0d]: got %0h, required queued entry", tag, i, act);
            end else begin
                req = exp_q.pop_front();
                check($sformatf("%s[%0d]", tag, i), 32'(act), 32'(req));
            end
        end
        vecs.delete();
    endtask

    // One-cycle reset; optionally with a sample in flight that must be dropped.
    task automatic do_reset(input string tag, input logic in_flight);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = in_flight;
        bus.value    = 8'h55;
        clr_stats    = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_outs"}, 32'({bus.op_valid, bus.op_out, bus.err, bus.locked}), 32'd0);
        check({tag, "_cnts"}, 32'({cnt_inc1, cnt_dec1, cnt_inc2, cnt_dec2, err_cnt}), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int i1, input int d1,
                              input int i2, input int d2, input int er);
        check({tag, "_inc1"}, 32'(cnt_inc1), 32'(i1));
        check({tag, "_dec1"}, 32'(cnt_dec1), 32'(d1));
        check({tag, "_inc2"}, 32'(cnt_inc2), 32'(i2));
        check({tag, "_dec2"}, 32'(cnt_dec2), 32'(d2));
        check({tag, "_err"},  32'(err_cnt),  32'(er));
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        clr_stats    = 1'b0;
        bus.in_valid = 1'b0;
        bus.value    = '0;
        repeat (2) @(posedge clk);

        // Basic decode of all four ops.
        do_reset("rst0", 1'b0);
        add(1, 8'h10, 0, e(0, 2'b00, 0, 1));
        add(1, 8'h11, 0, e(1, 2'b00, 0, 1));
        add(1, 8'h13, 0, e(1, 2'b10, 0, 1));
        add(1, 8'h12, 0, e(1, 2'b01, 0, 1));
        add(1, 8'h10, 0, e(1, 2'b11, 0, 1));
        run_vecs("ops");
        check_cnts("ops", 1, 1, 1, 1, 0);

        // Wrap-around steps.
        do_reset("rst1", 1'b0);
        add(1, 8'hFE, 0, e(0, 2'b00, 0, 1));
        add(1, 8'hFF, 0, e(1, 2'b00, 0, 1));
        add(1, 8'h00, 0, e(1, 2'b00, 0, 1));
        add(1, 8'hFE, 0, e(1, 2'b11, 0, 1));
        run_vecs("wrap");
        check_cnts("wrap", 2, 0, 0, 1, 0);

        // Error run into LOST, silent illegal in LOST, re-lock, resume.
        do_reset("rst2", 1'b0);
        add(1, 8'h20, 0, e(0, 2'b00, 0, 1));
        add(1, 8'h20, 0, e(0, 2'b00, 1, 1));
        add(1, 8'h25, 0, e(0, 2'b00, 1, 1));
        add(1, 8'h30, 0, e(0, 2'b00, 1, 0));
        add(1, 8'h40, 0, e(0, 2'b00, 0, 0));
        add(1, 8'h41, 0, e(0, 2'b00, 0, 1));
        add(1, 8'h42, 0, e(1, 2'b00, 0, 1));
        run_vecs("errs");
        check_cnts("errs", 1, 0, 0, 0, 3);

        // Gap: sample without in_valid is ignored.
        do_reset("rst3", 1'b0);
        add(1, 8'h05, 0, e(0, 2'b00, 0, 1));
        add(0, 8'h99, 0, e(0, 2'b00, 0, 1));
        add(1, 8'h06, 0, e(1, 2'b00, 0, 1));
        run_vecs("gap");
        check_cnts("gap", 1, 0, 0, 0, 0);

        // Saturation at 3 with six +1 steps (random start value).
        do_reset("rst4", 1'b0);
        begin
            logic [W-1:0] base;
            base = W'($urandom_range(0, 255));
            add(1, base, 0, e(0, 2'b00, 0, 1));
            for (int k = 1; k <= 6; k++) add(1, base + W'(k), 0, e(1, 2'b00, 0, 1));
            run_vecs("sat");
            check_cnts("sat", 3, 0, 0, 0, 0);
            // Clear together with a +1 step: clear wins, op still pulses.
            add(1, base + W'(7), 1, e(1, 2'b00, 0, 1));
            run_vecs("clr");
            check_cnts("clr", 0, 0, 0, 0, 0);
            // Counting resumes after the clear.
            add(1, base + W'(9), 0, e(1, 2'b10, 0, 1));
            run_vecs("post_clr");
            check_cnts("post_clr", 0, 0, 1, 0, 0);
        end

        // Reset mid-stream while tracking, with a sample in flight.
        do_reset("rst5", 1'b1);
        add(1, 8'h08, 0, e(0, 2'b00, 0, 1));
        add(1, 8'h07, 0, e(1, 2'b01, 0, 1));
        run_vecs("after_rst");
        check_cnts("after_rst", 0, 1, 0, 0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
